// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared definitions for the CLB configuration path.
//   cfg_state_t - loader state encoding (IDLE, SHIFT, COMMIT, DONE)
//   cfg_clog2   - ceiling log2 usable in parameter expressions
//   cfg_word_w  - config word width derived from the half-LUT size
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } cfg_state_t;

  function automatic int cfg_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Two truth-table halves plus the fracture/split bit in the MSB.
  function automatic int cfg_word_w(input int mem_size);
    return 2 * mem_size + 1;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// cfg_shift_reg: W-bit serial-in / parallel-out register, MSB-first.
//   clk, rst   - clock, asynchronous active-high reset
//   clr_i      - synchronous clear (wins over shift)
//   shift_en_i - shift din_i into the LSB, older bits move toward the MSB
//   din_i      - serial data bit
//   q_o        - parallel contents
module cfg_shift_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         shift_en_i,
  input  logic         din_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (clr_i) begin
      shreg_q <= '0;
    end else if (shift_en_i) begin
      shreg_q <= {shreg_q[W-2:0], din_i};
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: deserializes a serial bitstream into LUT config words and
// loads NUM_LUTS downstream LUTs in order through a one-hot cen strobe.
//   cclk, rst   - config clock, asynchronous active-high reset
//   cfg_start   - begin / restart a load pass (ignored during COMMIT)
//   cfg_din     - serial config bit, MSB of each word first
//   cfg_valid   - cfg_din valid this cycle
//   cfg_ready   - loader accepts a bit this cycle
//   config_out  - current word, drives the shared downstream config_in bus
//   cen_out     - one-hot write strobe, high only for the single COMMIT cycle
//   lut_idx     - index of the LUT being filled
//   cfg_done    - whole bank configured
//   dbg_state   - current FSM state
//
// Handshake: a bit transfers on a cclk rising edge where cfg_valid and
// cfg_ready are both high; cfg_valid low simply stalls, and the bit presented
// in a cycle where cfg_start is high is dropped.
module lut_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int INPUTS     = 4,
  parameter int MEM_SIZE   = 2 ** INPUTS,
  parameter int WORD_W     = cfg_word_w(MEM_SIZE),
  parameter int NUM_LUTS   = 4,
  localparam int LIDX_W    = (NUM_LUTS > 1) ? cfg_clog2(NUM_LUTS) : 1
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_din,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] config_out,
  output logic [NUM_LUTS-1:0] cen_out,
  output logic [LIDX_W-1:0] lut_idx,
  output logic              cfg_done,
  output cfg_state_t        dbg_state
);

  localparam int BCNT_W = cfg_clog2(WORD_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
  localparam logic [LIDX_W-1:0] LAST_LUT = LIDX_W'(NUM_LUTS - 1);

  cfg_state_t          state_q, state_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LIDX_W-1:0]   lut_idx_q, lut_idx_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [NUM_LUTS-1:0] cen_q, cen_d;
  logic                shift_en;
  logic                shift_clr;

  cfg_shift_reg #(.W(WORD_W)) u_shreg (
    .clk        (cclk),
    .rst        (rst),
    .clr_i      (shift_clr),
    .shift_en_i (shift_en),
    .din_i      (cfg_din),
    .q_o        (config_out)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lut_idx_d = lut_idx_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          lut_idx_d = '0;
          shift_clr = 1'b1;
        end
      end
      SHIFT: begin
        // Restart takes priority over a bit offered in the same cycle.
        if (cfg_start) begin
          bit_cnt_d = '0;
          lut_idx_d = '0;
          shift_clr = 1'b1;
        end else if (cfg_valid && ready_q) begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (lut_idx_q == LAST_LUT) begin
          state_d = DONE;
        end else begin
          state_d   = SHIFT;
          lut_idx_d = lut_idx_q + 1'b1;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they come straight out of
    // flops; lut_idx does not advance until COMMIT ends, so lut_idx_d is the
    // index being committed.
    ready_d = (state_d == SHIFT);
    done_d  = (state_d == DONE);
    cen_d   = (state_d == COMMIT) ? (NUM_LUTS'(1) << lut_idx_d) : '0;
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      lut_idx_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cen_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      lut_idx_q <= lut_idx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cen_q     <= cen_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign cen_out   = cen_q;
  assign lut_idx   = lut_idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: randomized bench for lut_cfg_loader with a queue-based
// reference of expected LUT commits (strobe + word).
module tb_lut_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int WORD_W   = 33;
  localparam int NUM_LUTS = 4;
  localparam int LIDX_W   = 2;
  localparam int EXP_W    = NUM_LUTS + WORD_W;

  // ---------------- clock / reset ----------------
  logic                cclk = 1'b0;
  logic                rst  = 1'b1;
  logic                cfg_start = 1'b0;
  logic                cfg_din   = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [WORD_W-1:0]   config_out;
  logic [NUM_LUTS-1:0] cen_out;
  logic [LIDX_W-1:0]   lut_idx;
  logic                cfg_done;
  cfg_state_t          dbg_state;

  always #5 cclk = ~cclk;

  int cyc = 0;
  always @(posedge cclk) cyc <= cyc + 1;

  lut_cfg_loader #(.INPUTS(4), .NUM_LUTS(NUM_LUTS)) dut (
    .cclk       (cclk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_din    (cfg_din),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .cen_out    (cen_out),
    .lut_idx    (lut_idx),
    .cfg_done   (cfg_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               idx_m = 0;
  int               total = 0;
  int               bad   = 0;
  int               first_acc_cyc = 0;
  logic [EXP_W-1:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({config_out, cen_out, lut_idx, cfg_ready, cfg_done});
  endfunction

  // Every strobe must match the oldest completed word, in order.
  always @(negedge cclk) begin
    if (!rst && cen_out != '0) begin
      chk("cen_onehot", 64'($countones(cen_out)), 64'd1);
      chk("ready_in_commit", 64'(cfg_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_cen", 64'(cen_out), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit_cen", 64'(cen_out), 64'(mon_e[EXP_W-1:WORD_W]));
        chk("commit_word", 64'(config_out), 64'(mon_e[WORD_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge cclk);
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    @(posedge cclk);
    #1;
    cfg_start = 1'b0;
    idx_m = 0;
    chk("start_ready", 64'(cfg_ready), 64'd1);
    chk("start_done_clr", 64'(cfg_done), 64'd0);
    chk("start_idx", 64'(lut_idx), 64'd0);
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
  // stop_after >= 0 abandons the word after that many accepted bits.
  task automatic send_word(input logic [WORD_W-1:0] w, input int mode,
                           input int stop_after, input bit meas);
    int   acc;
    int   guard;
    logic rdy;
    logic v;
    acc = 0;
    guard = 0;
    while (acc < WORD_W && acc != stop_after && guard < 2000) begin
      @(negedge cclk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cfg_valid = v;
      cfg_din   = w[WORD_W-1-acc];
      rdy       = cfg_ready;
      if (meas && v && rdy && acc == 0) first_acc_cyc = cyc;
      @(posedge cclk);
      if (v && rdy) acc++;
      guard++;
    end
    if (guard >= 2000) chk("send_timeout", 64'(acc), 64'(WORD_W));
    if (acc == WORD_W) begin
      exp_q.push_back({NUM_LUTS'(1) << idx_m, w});
      idx_m++;
    end
  endtask

  task automatic wait_done(input string tag, output int done_cyc);
    int i;
    i = 0;
    while (!cfg_done && i < 300) begin
      @(negedge cclk);
      i++;
    end
    done_cyc = cyc;
    chk(tag, 64'(cfg_done), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_state", 64'(dbg_state), 64'(DONE));
    chk("done_ready", 64'(cfg_ready), 64'd0);
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  logic [WORD_W-1:0] words[4];
  int                done_cyc;

  initial begin
    words[0] = 33'h0_0000_FFFF;
    words[1] = 33'h1_AAAA_5555;
    words[2] = 33'h0_FFFF_0000;
    words[3] = 33'h1_0F0F_F0F0;

    // Reset then idle.
    repeat (3) @(negedge cclk);
    rst = 1'b0;
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    for (int i = 0; i < 20; i++) begin
      @(negedge cclk);
      chk("idle_outs", all_outs(), 64'd0);
    end

    // Single known word into LUT 0.
    do_start();
    send_word(33'h1_2345_6789, 0, -1, 1'b0);
    @(negedge cclk);
    cfg_valid = 1'b0;
    @(negedge cclk);
    chk("idx_after_first", 64'(lut_idx), 64'd1);

    // Full pass with valid toggling every other cycle.
    do_start();
    for (int i = 0; i < 4; i++) send_word(words[i], 1, -1, 1'b0);
    wait_done("done_stalled", done_cyc);
    cfg_valid = 1'b0;

    // Reload from DONE with valid held high; measure pass latency.
    do_start();
    for (int i = 0; i < 4; i++) send_word(rand_word(), 0, -1, (i == 0));
    wait_done("done_reload", done_cyc);
    cfg_valid = 1'b0;
    chk("pass_latency", 64'(done_cyc - first_acc_cyc), 64'(NUM_LUTS * (WORD_W + 1)));

    // Abort after 10 bits of the word for LUT 1.
    do_start();
    send_word(rand_word(), 2, -1, 1'b0);
    send_word(rand_word(), 2, 10, 1'b0);
    @(negedge cclk);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'($urandom_range(0, 1));
    @(posedge cclk);
    #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    idx_m = 0;
    chk("abort_idx", 64'(lut_idx), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(SHIFT));
    send_word(rand_word(), 2, -1, 1'b0);
    send_word(rand_word(), 2, -1, 1'b0);

    // Async reset during bit 20 of the word for LUT 2.
    send_word(rand_word(), 2, 20, 1'b0);
    @(negedge cclk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", all_outs(), 64'd0);
    chk("async_rst_state", 64'(dbg_state), 64'(IDLE));
    cfg_valid = 1'b0;
    repeat (3) @(negedge cclk);
    rst = 1'b0;
    chk("post_rst_queue", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge cclk);

    // Fresh pass after reset.
    do_start();
    for (int i = 0; i < 4; i++) send_word(rand_word(), 2, -1, 1'b0);
    wait_done("done_after_rst", done_cyc);
    cfg_valid = 1'b0;

    // DONE holds with no strobes.
    for (int i = 0; i < 5; i++) begin
      @(negedge cclk);
      chk("done_hold", 64'({cfg_done, cen_out}), 64'({1'b1, 4'b0000}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Configuration front-end that sits directly upstream of the fracturable LUT bank.
- Accepts a serial bitstream over a valid/ready handshake and deserializes it into one LUT config word at a time.
- Drives the shared config_in bus and a one-hot per-LUT cen strobe, loading NUM_LUTS LUTs in order.
- Asserts cfg_done once the whole bank is configured.

Parameters:
- INPUTS, 4, LUT input count per half; must match the downstream LUT.
- MEM_SIZE, 2**INPUTS, truth-table bits per half-LUT.
- WORD_W, 2*MEM_SIZE+1, config word width; MSB is the fracture/split bit (33 at defaults).
- NUM_LUTS, 4, number of downstream LUTs loaded per pass.

Ports:
- cclk  input  1  configuration clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  begin or restart a load pass.
- cfg_din  input  1  serial config bit, MSB first.
- cfg_valid  input  1  cfg_din is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle.
- config_out  output  WORD_W  config word; drives downstream config_in.
- cen_out  output  NUM_LUTS  one-hot write strobe; bit i drives cen of LUT i.
- lut_idx  output  clog2(NUM_LUTS)  index of the LUT currently being filled.
- cfg_done  output  1  all NUM_LUTS words committed.

Behaviour:
- Reset (async, rst=1) clears everything immediately:
  - state=IDLE, shreg=0, bit_cnt=0, lut_idx=0.
  - config_out=0, cen_out=0, cfg_ready=0, cfg_done=0.
- A reset mid-pass aborts the pass; no partial cen pulse is ever produced.
- States are IDLE, SHIFT, COMMIT, DONE.
- IDLE: cfg_ready=0. cfg_start=1 -> SHIFT with bit_cnt=0, lut_idx=0, cfg_done=0.
- SHIFT:
  - cfg_ready=1.
  - Bit accepted on a cclk edge when cfg_valid & cfg_ready: shreg <= {shreg[WORD_W-2:0], cfg_din}; bit_cnt++.
  - Accepting the bit with bit_cnt==WORD_W-1 moves to COMMIT. The first bit received lands in config_out[WORD_W-1].
  - cfg_valid low stalls the load with no state change.
  - cfg_start=1 in SHIFT aborts and restarts at lut_idx=0, bit_cnt=0. Any bit presented that cycle is discarded.
- COMMIT (exactly 1 cycle):
  - cfg_ready=0.
  - cen_out = 1<<lut_idx, decoded from registered state and lut_idx, so it is glitch-free.
  - config_out is stable and equals the full word; the LUT captures it on the edge that ends COMMIT.
  - If lut_idx==NUM_LUTS-1 -> DONE; otherwise lut_idx++, bit_cnt=0 -> SHIFT.
  - cfg_start is ignored in COMMIT.
- DONE: cfg_done=1, cfg_ready=0, cen_out=0. cfg_start -> SHIFT with counters cleared and cfg_done=0 on the next cycle.
- config_out = shreg at all times. It may change during SHIFT; this is harmless because cen_out=0 outside COMMIT.
- Latency: with cfg_valid held high, a pass takes NUM_LUTS*(WORD_W+1) cycles from the first accepted bit to cfg_done=1. That is 136 cycles at defaults.
- Width rules:
  - bit_cnt is clog2(WORD_W+1) bits.
  - lut_idx does not wrap past NUM_LUTS-1.
  - NUM_LUTS=1 is legal: lut_idx is held at width 1, constant 0.
- cen_out is never multi-hot and never asserted outside COMMIT.

Decomposition:
- Shared package clb_cfg_pkg holds:
  - the state encoding: IDLE=2'd0, SHIFT=2'd1, COMMIT=2'd2, DONE=2'd3;
  - the WORD_W derivation from INPUTS;
  - a clog2 helper.
- One natural sub-module, cfg_shift_reg: a WORD_W-bit serial-in/parallel-out register with shift enable and synchronous clear.
- The FSM, counters and cen decode stay in lut_cfg_loader.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, release, no cfg_start -> all outputs 0 for 20 cycles, cfg_ready=0.
- Single word: pulse cfg_start, stream 33 bits of 33'h1_2345_6789 MSB-first with cfg_valid=1 -> one COMMIT cycle with cen_out=4'b0001 and config_out=33'h1_2345_6789; lut_idx becomes 1.
- Full pass with stalls: 4 words 33'h0_0000_FFFF, 33'h1_AAAA_5555, 33'h0_FFFF_0000, 33'h1_0F0F_F0F0, with cfg_valid toggling every other cycle -> cen_out pulses 0001, 0010, 0100, 1000, each paired with the matching word; cfg_done=1 afterwards; no bit is lost or duplicated.
- Abort: cfg_start asserted after 10 bits of word 2 (lut_idx=1) -> lut_idx=0, bit_cnt=0; the next 33 bits commit to LUT 0 with cen_out=0001.
- Async reset mid-pass: assert rst during bit 20 of word 3 -> outputs clear without waiting for a cclk edge; no cen pulse for LUT 2; a new cfg_start pass completes normally.
- Reload from DONE: cfg_start in DONE -> cfg_done deasserts the next cycle; a second 4-word pass produces cen_out 0001..1000 again with the new data.
